ssd_value_source: RTL and testbench

Upstream feeder for the four-digit seven-segment display driver. Selects one of four 32-bit processor observation buses (PC, instruction, register read data, ALU result), steps through them on a debounced push-button, saturates the chosen value to the 13-bit display range (0–8191) and holds it in a register. Holding the value keeps the BCD digits stable between refresh ticks. `num` connects directly to the display driver's `num` input.

---
 rtl/ssd_value_source.sv | 114 +++++++++++
 tb/tb_ssd_value_source.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_value_source.sv
// Display value feeder: picks one of four observation buses with a debounced
// button, saturates it to 13 bits and holds it steady for the digit driver.
module ssd_value_source #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [23:0] HOLD_CYCLES     = 24'd5000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn,
   input  logic        freeze,
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   input  logic [31:0] reg_data,
   input  logic [31:0] alu_result,
   output logic [12:0] num,
   output logic        ovf,
   output logic [1:0]  mode
);

   localparam logic [15:0] DB_LAST   = DEBOUNCE_CYCLES - 16'd1;
   localparam logic [23:0] HOLD_LAST = HOLD_CYCLES - 24'd1;

   logic        sync1;
   logic        sync2;
   logic        stable;
   logic        stable_d;
   logic        reload_pend;
   logic [15:0] db_cnt;
   logic [23:0] hold_cnt;
   logic        press;
   logic        tick;
   logic        load;
   logic [31:0] src;
   logic        src_big;

   assign press   = stable & ~stable_d;
   assign tick    = (hold_cnt == HOLD_LAST);
   assign load    = (tick | reload_pend) & ~freeze;
   assign src_big = |src[31:13];

   always_comb begin
      src = pc;
      case (mode)
         2'd0:    src = pc;
         2'd1:    src = instr;
         2'd2:    src = reg_data;
         default: src = alu_result;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // Any return to the stable level restarts the count, so short bounces vanish.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stable <= 1'b0;
         db_cnt <= '0;
      end else if (sync2 == stable) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         stable <= sync2;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stable_d <= 1'b0;
         mode     <= 2'd0;
      end else begin
         stable_d <= stable;
         if (press) begin
            mode <= mode + 2'd1;
         end
      end
   end

   // A press coinciding with a load re-arms the request so the new source follows.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         num         <= '0;
         ovf         <= 1'b0;
         hold_cnt    <= '0;
         reload_pend <= 1'b0;
      end else begin
         if (load) begin
            num      <= src_big ? 13'h1FFF : src[12:0];
            ovf      <= src_big;
            hold_cnt <= '0;
         end else if (tick) begin
            hold_cnt <= '0;
         end else begin
            hold_cnt <= hold_cnt + 24'd1;
         end

         if (press) begin
            reload_pend <= 1'b1;
         end else if (load) begin
            reload_pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ssd_value_source.sv
// Scoreboard bench for ssd_value_source: stimulus queues expected outputs per
// clock edge, an independent monitor compares them on the falling edge.
module tb_ssd_value_source;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn = 1'b0;
   logic        freeze = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] instr = '0;
   logic [31:0] reg_data = '0;
   logic [31:0] alu_result = '0;
   logic [12:0] num;
   logic        ovf;
   logic [1:0]  mode;

   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      int unsigned at;
      logic [12:0] num;
      logic        ovf;
      logic [1:0]  mode;
      string       name;
   } exp_t;

   exp_t sb[$];

   ssd_value_source #(
      .DEBOUNCE_CYCLES(16'd4),
      .HOLD_CYCLES    (24'd8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn),
      .freeze     (freeze),
      .pc         (pc),
      .instr      (instr),
      .reg_data   (reg_data),
      .alu_result (alu_result),
      .num        (num),
      .ovf        (ovf),
      .mode       (mode)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic expect_at(input int unsigned at, input logic [12:0] n,
                            input logic o, input logic [1:0] m, input string name);
      exp_t e;
      e.at   = at;
      e.num  = n;
      e.ovf  = o;
      e.mode = m;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic at_edge(input int unsigned n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(output int unsigned r);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      r   = cyc;
      rst = 1'b1;
   endtask

   // Monitor: compare every queued expectation on the falling edge of its cycle.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
               checks++;
               if ({num, ovf, mode} !== {sb[i].num, sb[i].ovf, sb[i].mode}) begin
                  errors++;
                  $display("FAIL %s @edge %0d: num=%0d ovf=%0b mode=%0d, required num=%0d ovf=%0b mode=%0d",
                           sb[i].name, cyc, num, ovf, mode, sb[i].num, sb[i].ovf, sb[i].mode);
               end
               sb.delete(i);
            end else if (sb[i].at < cyc) begin
               checks++;
               errors++;
               $display("FAIL %s: edge %0d passed without a sample", sb[i].name, sb[i].at);
               sb.delete(i);
            end
         end
      end
   end

   initial begin
      int unsigned r;
      int unsigned e;
      int unsigned s;
      int unsigned f;
      int unsigned t;
      int unsigned g;
      logic [12:0] vals [4];
      logic [12:0] pv;
      logic [12:0] nv;
      logic [1:0]  nm;

      // Reset, first tick, periodic reload
      pc = 32'd1234;
      #2;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      expect_at(cyc, 13'd0, 1'b0, 2'd0, "reset_hold");
      r   = cyc;
      rst = 1'b1;
      expect_at(r + 1, 13'd0, 1'b0, 2'd0, "post_reset");
      expect_at(r + 7, 13'd0, 1'b0, 2'd0, "pre_first_tick");
      expect_at(r + 8, 13'd1234, 1'b0, 2'd0, "first_tick");
      at_edge(r + 8);
      pc = 32'd99;
      expect_at(r + 15, 13'd1234, 1'b0, 2'd0, "hold_between_ticks");
      expect_at(r + 16, 13'd99, 1'b0, 2'd0, "tick_reload_99");

      // Saturation
      at_edge(r + 16);
      pc = 32'd8191;
      expect_at(r + 24, 13'd8191, 1'b0, 2'd0, "sat_8191");
      at_edge(r + 24);
      pc = 32'd8192;
      expect_at(r + 32, 13'd8191, 1'b1, 2'd0, "sat_8192");
      at_edge(r + 32);
      pc = 32'hFFFF_FFFF;
      expect_at(r + 40, 13'd8191, 1'b1, 2'd0, "sat_max");
      at_edge(r + 40);
      pc = 32'd0;
      expect_at(r + 48, 13'd0, 1'b0, 2'd0, "sat_clear");
      at_edge(r + 48);

      // Mode step and wrap, four clean presses
      pc = 32'd100;
      instr = 32'd5;
      reg_data = 32'd6;
      alu_result = 32'd7;
      vals[0] = 13'd100;
      vals[1] = 13'd5;
      vals[2] = 13'd6;
      vals[3] = 13'd7;
      do_reset(r);
      for (int k = 0; k < 4; k++) begin
         e  = r + 16 * k;
         pv = (k == 0) ? 13'd0 : vals[k];
         nm = 2'(k + 1);
         nv = vals[nm];
         at_edge(e);
         btn = 1'b1;
         expect_at(e + 6, pv, 1'b0, 2'(k), "press_before_step");
         expect_at(e + 7, pv, 1'b0, nm, "press_mode_step");
         expect_at(e + 8, nv, 1'b0, nm, "press_new_source");
         at_edge(e + 8);
         btn = 1'b0;
         expect_at(e + 15, nv, 1'b0, nm, "release_no_step");
      end

      // Bounce rejection: 3 high, 2 low, 3 high
      s = r + 64;
      at_edge(s);
      btn = 1'b1;
      at_edge(s + 3);
      btn = 1'b0;
      at_edge(s + 5);
      btn = 1'b1;
      at_edge(s + 8);
      btn = 1'b0;
      expect_at(s + 12, 13'd100, 1'b0, 2'd0, "bounce_mid");
      expect_at(s + 20, 13'd100, 1'b0, 2'd0, "bounce_reject");

      // Freeze: mode advances, num held, pending reload on unfreeze
      f = s + 24;
      at_edge(f);
      freeze = 1'b1;
      btn = 1'b1;
      expect_at(f + 7, 13'd100, 1'b0, 2'd1, "freeze_mode_step");
      expect_at(f + 8, 13'd100, 1'b0, 2'd1, "freeze_no_load");
      at_edge(f + 1);
      instr = 32'd55;
      at_edge(f + 10);
      btn = 1'b0;
      expect_at(f + 27, 13'd100, 1'b0, 2'd1, "freeze_hold20");
      at_edge(f + 27);
      freeze = 1'b0;
      expect_at(f + 28, 13'd55, 1'b0, 2'd1, "unfreeze_load");
      at_edge(f + 28);
      instr = 32'd66;
      expect_at(f + 35, 13'd55, 1'b0, 2'd1, "unfreeze_hold");
      expect_at(f + 36, 13'd66, 1'b0, 2'd1, "unfreeze_tick_restart");

      // Press landing on a tick edge: tick loads old mode, new mode loads next
      t = f + 52;
      at_edge(f + 44);
      instr = 32'd88;
      at_edge(f + 45);
      btn = 1'b1;
      expect_at(t - 1, 13'd66, 1'b0, 2'd1, "collision_before");
      expect_at(t, 13'd88, 1'b0, 2'd2, "collision_old_mode");
      expect_at(t + 1, 13'd6, 1'b0, 2'd2, "collision_new_mode");
      at_edge(t + 1);
      btn = 1'b0;
      reg_data = 32'd77;
      expect_at(t + 8, 13'd6, 1'b0, 2'd2, "collision_hold");
      expect_at(t + 9, 13'd77, 1'b0, 2'd2, "collision_next_tick");

      // Reset in the middle of a debounce
      g = t + 12;
      at_edge(g);
      pc = 32'd321;
      btn = 1'b1;
      at_edge(g + 3);
      rst = 1'b0;
      btn = 1'b0;
      expect_at(g + 3, 13'd0, 1'b0, 2'd0, "reset_async");
      at_edge(g + 6);
      rst = 1'b1;
      expect_at(g + 13, 13'd0, 1'b0, 2'd0, "post_reset_hold");
      expect_at(g + 14, 13'd321, 1'b0, 2'd0, "post_reset_tick");
      expect_at(g + 20, 13'd321, 1'b0, 2'd0, "reset_press_lost");
      at_edge(g + 22);

      @(negedge clk);
      #1;
      while (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s: edge %0d never sampled", sb[0].name, sb[0].at);
         sb.delete(0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
